// File: rtl/snake_pkg.sv
// Shared encodings for the snake game sequencer and its logic datapath.
package snake_pkg;

    typedef enum logic [1:0] {
        GAME_INIT  = 2'd0,
        GAME_RUN   = 2'd1,
        GAME_STOP  = 2'd2,
        GAME_PAUSE = 2'd3
    } game_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        EXEC_UPDATE     = 3'd0,
        EXEC_CHECK      = 3'd1,
        EXEC_INPUT      = 3'd2,
        EXEC_WAIT_LOGIC = 3'd3,
        EXEC_DISPLAY    = 3'd4
    } exec_t;

    localparam logic [3:0] BTN_UP    = 4'b0001;
    localparam logic [3:0] BTN_DOWN  = 4'b0010;
    localparam logic [3:0] BTN_LEFT  = 4'b0100;
    localparam logic [3:0] BTN_RIGHT = 4'b1000;

    // True when exactly one direction button is held.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v == BTN_UP) || (v == BTN_DOWN) || (v == BTN_LEFT) || (v == BTN_RIGHT);
    endfunction

    // Map a one-hot button pattern onto a direction code.
    function automatic dir_t btn_to_dir(input logic [3:0] v);
        dir_t d;
        case (v)
            BTN_UP:   d = DIR_UP;
            BTN_DOWN: d = DIR_DOWN;
            BTN_LEFT: d = DIR_LEFT;
            default:  d = DIR_RIGHT;
        endcase
        return d;
    endfunction

    // Bit 1 of the code selects the axis; a turn is only legal onto the other axis,
    // which rejects both reversals and repeats of the current heading.
    function automatic logic turn_allowed(input logic [1:0] cur, input logic [1:0] req);
        return cur[1] != req[1];
    endfunction

endpackage

// File: rtl/snake_sequencer_dir_queue.sv
// Small FIFO holding pending direction requests between game ticks.
module dir_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign dout  = mem_r[rd_ptr_r];

    // Guard the request pair: a push into a full queue only lands when a pop frees the slot.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/snake_sequencer.sv
// Snake game control sequencer: input capture, game/exec FSM and LED row scan.
module snake_sequencer
    import snake_pkg::*;
#(
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int DISP_CYCLES   = 2,
    parameter int DIR_DEPTH     = 2,
    parameter int LOGIC_TIMEOUT = 255
) (
    input  logic                 clka,
    input  logic                 restart_n,
    input  logic [3:0]           dir_in,
    input  logic                 pause_in,
    input  logic                 logic_done,
    input  logic                 game_end,
    input  logic [ROWS*COLS-1:0] led_array_flat,
    output logic [1:0]           game_state,
    output logic [1:0]           direction_state,
    output logic [2:0]           exec_state,
    output logic                 logic_tick,
    output logic                 no_update,
    output logic [ROWS-1:0]      row_cathode,
    output logic [COLS-1:0]      column_anode,
    output logic                 dir_overflow
);

    localparam int RW = $clog2(ROWS);
    localparam int FW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam int TW = $clog2(LOGIC_TIMEOUT + 1);

    exec_t         exec_r, exec_next_s;
    game_t         game_r, game_next_s;
    dir_t          dir_r, dir_next_s;
    dir_t          press_dir_s, head_s;
    logic [1:0]    head_raw_s;
    logic [3:0]    dir_prev_r;
    logic          pause_prev_r, pause_latch_r;
    logic          timed_out_r, timed_out_next_s;
    logic [RW-1:0] row_cnt_r, row_next_s;
    logic [FW-1:0] frame_cnt_r, frame_next_s;
    logic [TW-1:0] to_cnt_r, to_next_s;
    logic [ROWS-1:0] row_cathode_r;
    logic          logic_tick_r, no_update_r, overflow_r;
    logic          press_s, accept_s, push_s, pop_s, drop_s;
    logic          full_s, empty_s, pause_rise_s, pause_pending_s;
    logic [COLS-1:0] column_s;

    dir_queue #(
        .DEPTH (DIR_DEPTH),
        .WIDTH (2)
    ) u_dir_queue (
        .clk   (clka),
        .rst_n (restart_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (press_dir_s),
        .dout  (head_raw_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign head_s          = dir_t'(head_raw_s);
    assign game_state      = game_r;
    assign direction_state = dir_r;
    assign exec_state      = exec_r;
    assign logic_tick      = logic_tick_r;
    assign no_update       = no_update_r;
    assign row_cathode     = row_cathode_r;
    assign column_anode    = column_s;
    assign dir_overflow    = overflow_r;

    // Button edge detection and queue handshake; presses are ignored while paused or stopped.
    always_comb begin
        press_s         = is_onehot4(dir_in) && (dir_in != dir_prev_r);
        press_dir_s     = btn_to_dir(dir_in);
        pop_s           = (exec_r == EXEC_INPUT) && !empty_s;
        accept_s        = press_s && (game_r != GAME_PAUSE) && (game_r != GAME_STOP);
        push_s          = accept_s && (!full_s || pop_s);
        drop_s          = accept_s && full_s && !pop_s;
        pause_rise_s    = pause_in && !pause_prev_r;
        pause_pending_s = pause_latch_r || pause_rise_s;
    end

    // Next-state logic for the exec sequence, game state, heading and scan counters.
    always_comb begin
        exec_next_s      = exec_r;
        game_next_s      = game_r;
        dir_next_s       = dir_r;
        timed_out_next_s = timed_out_r;
        row_next_s       = {RW{1'b0}};
        frame_next_s     = {FW{1'b0}};
        to_next_s        = {TW{1'b0}};
        case (exec_r)
            EXEC_UPDATE: begin
                exec_next_s      = EXEC_CHECK;
                timed_out_next_s = 1'b0;
                case (game_r)
                    GAME_INIT: begin
                        if (!empty_s) begin
                            game_next_s = GAME_RUN;
                        end else begin
                            game_next_s = GAME_INIT;
                        end
                    end
                    GAME_RUN: begin
                        if (game_end || timed_out_r) begin
                            game_next_s = GAME_STOP;
                        end else if (pause_pending_s) begin
                            game_next_s = GAME_PAUSE;
                        end else begin
                            game_next_s = GAME_RUN;
                        end
                    end
                    GAME_PAUSE: begin
                        if (pause_pending_s) begin
                            game_next_s = GAME_RUN;
                        end else begin
                            game_next_s = GAME_PAUSE;
                        end
                    end
                    GAME_STOP: game_next_s = GAME_STOP;
                    default:   game_next_s = GAME_INIT;
                endcase
            end
            EXEC_CHECK: begin
                if ((game_r == GAME_INIT) || (game_r == GAME_PAUSE)) begin
                    exec_next_s = EXEC_DISPLAY;
                end else begin
                    exec_next_s = EXEC_INPUT;
                end
            end
            EXEC_INPUT: begin
                exec_next_s = EXEC_WAIT_LOGIC;
                if (pop_s && turn_allowed(dir_r, head_s)) begin
                    dir_next_s = head_s;
                end else begin
                    dir_next_s = dir_r;
                end
            end
            EXEC_WAIT_LOGIC: begin
                if (logic_done) begin
                    exec_next_s      = EXEC_DISPLAY;
                    timed_out_next_s = 1'b0;
                end else if (to_cnt_r == TW'(LOGIC_TIMEOUT - 1)) begin
                    exec_next_s      = EXEC_DISPLAY;
                    timed_out_next_s = 1'b1;
                end else begin
                    to_next_s = to_cnt_r + TW'(1);
                end
            end
            EXEC_DISPLAY: begin
                if (row_cnt_r == RW'(ROWS - 1)) begin
                    if (frame_cnt_r == FW'(DISP_CYCLES - 1)) begin
                        exec_next_s = EXEC_UPDATE;
                    end else begin
                        frame_next_s = frame_cnt_r + FW'(1);
                    end
                end else begin
                    row_next_s   = row_cnt_r + RW'(1);
                    frame_next_s = frame_cnt_r;
                end
            end
            default: exec_next_s = EXEC_UPDATE;
        endcase
    end

    // Column data follows the live LED image for the row being scanned this cycle.
    always_comb begin
        if (exec_r == EXEC_DISPLAY) begin
            column_s = led_array_flat[int'(row_cnt_r) * COLS +: COLS];
        end else begin
            column_s = {COLS{1'b0}};
        end
    end

    // State registers and registered outputs, cleared by the synchronous restart.
    always_ff @(posedge clka) begin
        if (!restart_n) begin
            exec_r        <= EXEC_UPDATE;
            game_r        <= GAME_INIT;
            dir_r         <= DIR_RIGHT;
            dir_prev_r    <= 4'b0000;
            pause_prev_r  <= 1'b0;
            pause_latch_r <= 1'b0;
            timed_out_r   <= 1'b0;
            row_cnt_r     <= {RW{1'b0}};
            frame_cnt_r   <= {FW{1'b0}};
            to_cnt_r      <= {TW{1'b0}};
            row_cathode_r <= {ROWS{1'b1}};
            logic_tick_r  <= 1'b0;
            no_update_r   <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            exec_r        <= exec_next_s;
            game_r        <= game_next_s;
            dir_r         <= dir_next_s;
            dir_prev_r    <= dir_in;
            pause_prev_r  <= pause_in;
            pause_latch_r <= (exec_r == EXEC_UPDATE) ? 1'b0 : pause_pending_s;
            timed_out_r   <= timed_out_next_s;
            row_cnt_r     <= row_next_s;
            frame_cnt_r   <= frame_next_s;
            to_cnt_r      <= to_next_s;
            row_cathode_r <= (exec_next_s == EXEC_DISPLAY) ? ~(ROWS'(1) << row_next_s)
                                                           : {ROWS{1'b1}};
            logic_tick_r  <= (exec_next_s == EXEC_INPUT);
            no_update_r   <= (exec_next_s == EXEC_INPUT) && (game_next_s == GAME_STOP);
            overflow_r    <= overflow_r || drop_s;
        end
    end

endmodule
